// File: rtl/mf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mf_pkg                                                       |
// | Description : Shared types and constants for the UART transmit arbiter:    |
// |               arbiter state encoding, end-of-line character and a state    |
// |               to one-hot grant helper.                                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package mf_pkg;

  // Arbiter ownership states: nobody, console (req0), game/status (req1).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } uart_arb_state_t;

  // Byte that terminates a text line and releases a line lock.
  localparam logic [7:0] MF_EOL_CHAR = 8'h0A;

  // One-hot owner vector for a state; IDLE maps to no owner.
  function automatic logic [1:0] state_onehot(input uart_arb_state_t st);
    logic [1:0] oh;
    oh = 2'b00;
    case (st)
      LOCK0:   oh = 2'b01;
      LOCK1:   oh = 2'b10;
      default: oh = 2'b00;
    endcase
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arb_rr_pick                                                  |
// | Description : Combinational two-way pick. A lone valid wins outright; on a |
// |               tie the round-robin pointer chooses. Result is one-hot, or   |
// |               2'b00 when no requester is valid.                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module arb_rr_pick (
  input  logic [1:0] valid,
  input  logic       rr,
  output logic [1:0] pick
);

  // Resolve the winner from the valid pattern and the tie-break pointer.
  always_comb begin
    pick = 2'b00;
    case (valid)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = rr ? 2'b10 : 2'b01;
      default: pick = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_arb                                                  |
// | Description : Two-requester arbiter for the single UART transmitter. The   |
// |               console stream (req0) and the game/status reporter (req1)    |
// |               are granted the transmitter and their bytes pass through a   |
// |               one-entry output register.                                   |
// |               Build option UART_TX_ARB_LINE_LOCK_EN: when defined, a grant |
// |               lasts for a whole text line (released on 8'h0A or after      |
// |               LOCK_TIMEOUT idle cycles); when undefined, every accepted    |
// |               byte returns to arbitration (per-byte round robin).          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_tx_arb
  import mf_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic [1:0] grant
);

  localparam bit TIMEOUT_LEGAL = (LOCK_TIMEOUT >= 2) && (LOCK_TIMEOUT <= 65535);

  generate
    if (!TIMEOUT_LEGAL) begin : g_bad_timeout
      $error("uart_tx_arb: LOCK_TIMEOUT must lie in 2..65535");
    end
  endgenerate

  uart_arb_state_t r_state;
  uart_arb_state_t w_state_nxt;
  logic            r_rr;          // 0: req0 wins the next tie, 1: req1 wins
  logic            w_rr_nxt;
  logic [1:0]      r_grant;
  logic [1:0]      w_pick;
  logic            w_own_valid;
  logic [7:0]      w_own_data;
  logic            w_slot_free;
  logic            w_accept;
  logic            w_release;
  logic            r_tx_valid;
  logic [7:0]      r_tx_data;

  arb_rr_pick u_pick (
    .valid ({req1_valid, req0_valid}),
    .rr    (r_rr),
    .pick  (w_pick)
  );

  // The output register can take a byte if it is empty or draining this cycle.
  assign w_slot_free = !r_tx_valid || tx_ready;

  // Select the current owner's valid/data; no owner in IDLE.
  always_comb begin
    w_own_valid = 1'b0;
    w_own_data  = 8'h00;
    case (r_state)
      LOCK0: begin
        w_own_valid = req0_valid;
        w_own_data  = req0_data;
      end
      LOCK1: begin
        w_own_valid = req1_valid;
        w_own_data  = req1_data;
      end
      default: begin
        w_own_valid = 1'b0;
        w_own_data  = 8'h00;
      end
    endcase
  end

  assign req0_ready = (r_state == LOCK0) && w_slot_free;
  assign req1_ready = (r_state == LOCK1) && w_slot_free;
  assign w_accept   = w_own_valid && w_slot_free;

`ifdef UART_TX_ARB_LINE_LOCK_EN
  localparam int             CNT_W    = $clog2(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_idle_cnt;
  logic             w_eol;
  logic             w_timeout;

  assign w_eol     = w_accept && (w_own_data == MF_EOL_CHAR);
  assign w_timeout = (r_state != IDLE) && !w_own_valid && (r_idle_cnt == CNT_LAST);
  assign w_release = w_eol || w_timeout;

  // Count owner-silent cycles; a stall with valid high leaves it alone, and it saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if ((r_state == IDLE) || w_accept) begin
      r_idle_cnt <= '0;
    end else if (!w_own_valid && (r_idle_cnt != CNT_MAX)) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  // Per-byte arbitration: each accepted byte hands the transmitter back.
  assign w_release = w_accept;
`endif

  // Next owner and round-robin pointer.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    case (r_state)
      IDLE: begin
        if (w_pick[0]) begin
          w_state_nxt = LOCK0;
        end else if (w_pick[1]) begin
          w_state_nxt = LOCK1;
        end
      end
      LOCK0, LOCK1: begin
        if (w_release) begin
          w_state_nxt = IDLE;
`ifdef UART_TX_ARB_LINE_LOCK_EN
          // Hand priority to whoever did not just own the line.
          w_rr_nxt    = (r_state == LOCK0);
`else
          w_rr_nxt    = !r_rr;
`endif
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Arbiter state, round-robin pointer and the registered one-hot grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_grant <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      r_grant <= state_onehot(w_state_nxt);
    end
  end

  // One-entry output register: load on accept, otherwise clear when the UART takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else if (w_accept) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= w_own_data;
    end else if (tx_ready) begin
      r_tx_valid <= 1'b0;
    end
  end

  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign grant    = r_grant;

endmodule
`default_nettype wire
